// File: rtl/rv32_div_unit.sv
// Iterative 32-bit divider for RV32M DIV/DIVU/REM/REMU. It performs one restoring
// step per cycle and bypasses the loop for divide-by-zero and signed overflow.
module rv32_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            reg_write
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] quot_q, quot_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] divisor_q, divisor_d;
    logic            neg_quot_q, neg_quot_d;
    logic            neg_rem_q, neg_rem_d;
    logic            rem_sel_q, rem_sel_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [4:0]      rd_out_q, rd_out_d;

    logic            is_signed;
    logic [XLEN-1:0] abs_a, abs_b;
    logic            div_zero, sgn_ovf;
    logic [XLEN:0]   shifted, trial;
    logic [XLEN-1:0] fixed_quot, fixed_rem;

    always_comb begin
        is_signed = ~op[0];
        abs_a     = (is_signed && rs1_data[XLEN-1]) ? (~rs1_data + 1'b1) : rs1_data;
        abs_b     = (is_signed && rs2_data[XLEN-1]) ? (~rs2_data + 1'b1) : rs2_data;
        div_zero  = (rs2_data == '0);
        sgn_ovf   = is_signed && (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);

        // Bring in the next dividend bit and try subtracting; a borrow keeps the old remainder.
        shifted    = {rem_q, quot_q[XLEN-1]};
        trial      = shifted - {1'b0, divisor_q};

        fixed_quot = neg_quot_q ? (~quot_q + 1'b1) : quot_q;
        fixed_rem  = neg_rem_q  ? (~rem_q  + 1'b1) : rem_q;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        divisor_d  = divisor_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        rem_sel_d  = rem_sel_q;
        result_d   = result_q;
        rd_out_d   = rd_out_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    rem_sel_d = op[1];
                    rd_out_d  = rd_in;
                    cnt_d     = 6'd0;
                    divisor_d = abs_b;
                    if (div_zero || sgn_ovf) begin
                        // Pre-load the architectural answer; FIX then passes it through unsigned.
                        quot_d     = div_zero ? '1 : rs1_data;
                        rem_d      = div_zero ? rs1_data : '0;
                        neg_quot_d = 1'b0;
                        neg_rem_d  = 1'b0;
                        state_d    = FIX;
                    end else begin
                        quot_d     = abs_a;
                        rem_d      = '0;
                        neg_quot_d = is_signed && (rs1_data[XLEN-1] ^ rs2_data[XLEN-1]);
                        neg_rem_d  = is_signed && rs1_data[XLEN-1];
                        state_d    = CALC;
                    end
                end
            end
            CALC: begin
                if (cnt_q == 6'd32) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                    if (!trial[XLEN]) begin
                        rem_d  = trial[XLEN-1:0];
                        quot_d = {quot_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_d  = shifted[XLEN-1:0];
                        quot_d = {quot_q[XLEN-2:0], 1'b0};
                    end
                end
            end
            FIX: begin
                result_d = rem_sel_q ? fixed_rem : fixed_quot;
                state_d  = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 6'd0;
            quot_q     <= '0;
            rem_q      <= '0;
            divisor_q  <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            rem_sel_q  <= 1'b0;
            result_q   <= '0;
            rd_out_q   <= 5'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            divisor_q  <= divisor_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            rem_sel_q  <= rem_sel_d;
            result_q   <= result_d;
            rd_out_q   <= rd_out_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign result    = result_q;
    assign rd_out    = rd_out_q;
    assign reg_write = done && (rd_out_q != 5'd0);

endmodule

// File: tb/tb_rv32_div_unit.sv
// Directed bench for rv32_div_unit: it checks latency, results, rd and write-enable
// handling, bypass cases, ignored starts and reset abort.
module tb_rv32_div_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;
    logic        reg_write;

    int tests_run;
    int tests_failed;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    rv32_div_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .rd_in     (rd_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .rd_out    (rd_out),
        .reg_write (reg_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Issue one operation, then count edges from acceptance until done is seen.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_res, input int exp_edges);
        int edges;
        @(negedge clk);
        op = o; rs1_data = a; rs2_data = b; rd_in = rd; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check_val({tag, " busy_after_accept"}, 32'(busy), 32'd1);
        edges = 0;
        while (!done && edges < 100) begin
            @(posedge clk);
            #1 edges++;
        end
        check_val({tag, " done_edge"}, 32'(edges), 32'(exp_edges));
        check_val({tag, " result"}, result, exp_res);
        check_val({tag, " rd_out"}, 32'(rd_out), 32'(rd));
        check_val({tag, " reg_write"}, 32'(reg_write), 32'(rd != 5'd0));
        @(posedge clk);
        #1;
        check_val({tag, " done_single"}, 32'(done), 32'd0);
        check_val({tag, " idle_after"}, 32'(busy), 32'd0);
        check_val({tag, " result_hold"}, result, exp_res);
    endtask

    initial begin
        int edges;
        int done_seen;
        tests_run = 0;
        tests_failed = 0;
        reset = 1'b1; start = 1'b0; op = 2'b00;
        rs1_data = '0; rs2_data = '0; rd_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst busy", 32'(busy), 32'd0);
        check_val("rst done", 32'(done), 32'd0);
        check_val("rst result", result, 32'd0);
        check_val("rst rd_out", 32'(rd_out), 32'd0);
        check_val("rst reg_write", 32'(reg_write), 32'd0);
        reset = 1'b0;

        run_op("DIVU 100/7",    OP_DIVU, 32'd100,        32'd7,          5'd5,  32'd14,         34);
        run_op("REMU 100/7",    OP_REMU, 32'd100,        32'd7,          5'd5,  32'd2,          34);
        run_op("DIV -7/2",      OP_DIV,  32'hFFFF_FFF9,  32'd2,          5'd3,  32'hFFFF_FFFD,  34);
        run_op("REM -7/2",      OP_REM,  32'hFFFF_FFF9,  32'd2,          5'd3,  32'hFFFF_FFFF,  34);
        run_op("DIV 7/-2",      OP_DIV,  32'd7,          32'hFFFF_FFFE,  5'd4,  32'hFFFF_FFFD,  34);
        run_op("REM 7/-2",      OP_REM,  32'd7,          32'hFFFF_FFFE,  5'd4,  32'd1,          34);
        run_op("DIVU max/1",    OP_DIVU, 32'hFFFF_FFFF,  32'd1,          5'd31, 32'hFFFF_FFFF,  34);
        run_op("DIVU 5/0",      OP_DIVU, 32'd5,          32'd0,          5'd6,  32'hFFFF_FFFF,  1);
        run_op("REMU 5/0",      OP_REMU, 32'd5,          32'd0,          5'd6,  32'd5,          1);
        run_op("DIV -5/0",      OP_DIV,  32'hFFFF_FFFB,  32'd0,          5'd7,  32'hFFFF_FFFF,  1);
        run_op("REM -5/0",      OP_REM,  32'hFFFF_FFFB,  32'd0,          5'd7,  32'hFFFF_FFFB,  1);
        run_op("DIV ovf",       OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd8,  32'h8000_0000,  1);
        run_op("REM ovf",       OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd8,  32'd0,          1);
        run_op("DIVU 9/3 rd0",  OP_DIVU, 32'd9,          32'd3,          5'd0,  32'd3,          34);

        // Second start at edge 10 with other operands must not disturb the running divide.
        @(negedge clk);
        op = OP_DIVU; rs1_data = 32'd100; rs2_data = 32'd7; rd_in = 5'd9; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        op = OP_REMU; rs1_data = 32'd50; rs2_data = 32'd0; rd_in = 5'd1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        edges = 10;
        while (!done && edges < 100) begin
            @(posedge clk);
            #1 edges++;
        end
        check_val("restart done_edge", 32'(edges), 32'd34);
        check_val("restart result", result, 32'd14);
        check_val("restart rd_out", 32'(rd_out), 32'd9);

        // Start held in the DONE cycle must be dropped.
        start = 1'b1; op = OP_DIVU; rs1_data = 32'd8; rs2_data = 32'd0; rd_in = 5'd2;
        @(posedge clk);
        #1 start = 1'b0;
        check_val("done_start ignored busy", 32'(busy), 32'd0);
        check_val("done_start result", result, 32'd14);

        // Reset at edge 12 aborts the divide with no done pulse.
        @(negedge clk);
        op = OP_DIVU; rs1_data = 32'd100; rs2_data = 32'd7; rd_in = 5'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (11) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check_val("abort busy", 32'(busy), 32'd0);
        check_val("abort result", result, 32'd0);
        check_val("abort rd_out", 32'(rd_out), 32'd0);
        done_seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1 if (done) done_seen = 1;
        end
        check_val("abort no_done", 32'(done_seen), 32'd0);

        // Reset wins over a simultaneous start.
        @(negedge clk);
        op = OP_DIVU; rs1_data = 32'd9; rs2_data = 32'd0; rd_in = 5'd3;
        start = 1'b1; reset = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; reset = 1'b0;
        check_val("rst_vs_start busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check_val("rst_vs_start done", 32'(done), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
